pbkdf2_whirlpool_engine: RTL and testbench
==========================================

PBKDF2_WHIRLPOOL_ENGINE -- requirements
Module: pbkdf2_whirlpool_engine

Interface
REQ-001 Parameter ITER_W, default 20, width of the runtime iteration count.
REQ-002 Parameter BLK_IDX_W, default 8, width of the PBKDF2 block index input.
REQ-003 i_clk  in  1  clock; all logic on rising edge.
REQ-004 i_rstn  in  1  reset, asynchronous, active-low.
REQ-005 i_start  in  1  job request; accepted only while o_ready=1.
REQ-006 i_abort  in  1  synchronous job cancel.
REQ-007 i_pass  in  512  password, byte 0 at [511:504].
REQ-008 i_pass_len  in  7  password length in bytes, 0..64.
REQ-009 i_salt  in  512  salt block, used verbatim as second inner message block.
REQ-010 i_iter  in  ITER_W  iteration count c.
REQ-011 i_blk_idx  in  BLK_IDX_W  PBKDF2 block index i, zero-extended to 32 bits.
REQ-012 o_ready  out  1  idle, able to accept i_start.
REQ-013 o_key_valid / i_key_ready  out/in  1  derived-key handshake.
REQ-014 o_key  out  512  derived key T_i.
REQ-015 o_err  out  1  one-cycle pulse on rejected start.
REQ-016 o_cf_init / o_cf_data / o_cf_chain  out  1/512/512  compression request: pulse, message block, chaining value.
REQ-017 i_cf_valid / i_cf_out  in  1/512  compression result pulse and new chaining value.

Function
REQ-018 Start with i_pass_len>64: not accepted, o_err pulses one cycle, stays IDLE.
REQ-019 On accepted start, all inputs are latched; later input changes do not affect the job.
REQ-020 Password bytes at index >= i_pass_len are forced to zero; ikey = pass^{64{8'h36}}, okey = pass^{64{8'h5c}}, computed in state PAD.
REQ-021 i_iter=0 is treated as 1.
REQ-022 States: IDLE -> PAD -> I1 -> I2 -> I3 -> O1 -> O2 -> O3 -> ACC -> (I1 or DONE); DONE -> IDLE.
REQ-023 I1: chain 0, data ikey; I2: chain prev, data salt (iter 1) or U_prev (iter>1); I3: chain prev, data pad block.
REQ-024 Inner pad block: iter 1 = {idx32, 1'b1, 223'd0, 256'd1056}; iter>1 = {1'b1, 255'd0, 256'd1024}.
REQ-025 O1: chain 0, data okey; O2: data inner digest; O3: data {1'b1, 255'd0, 256'd1024}; O3 result = U_j.
REQ-026 One compression outstanding at most; o_cf_init is a one-cycle pulse; the next pulse is issued no earlier than the cycle after i_cf_valid.
REQ-027 i_cf_valid with no request outstanding is ignored.
REQ-028 ACC: accumulator ^= U_j, iteration counter increments; counter == c -> DONE, otherwise -> I1.
REQ-029 DONE: o_key = accumulator, o_key_valid held with o_key stable until i_key_ready=1; the transfer cycle returns to IDLE.
REQ-030 i_abort in any non-IDLE state: IDLE next cycle, o_key_valid cleared; a late i_cf_valid is ignored.
REQ-031 o_ready = 1 only in IDLE.

Reset
REQ-032 Asynchronous reset: state IDLE, o_ready=1, o_key_valid=0, o_key=0, o_err=0, o_cf_init=0, o_cf_data=0, o_cf_chain=0, counters and accumulator 0.
REQ-033 Reset mid-job discards the job; no o_key_valid follows.

Configuration
REQ-034 MIDSTATE_CACHE_EN defined: I1 and O1 results of iteration 1 are stored; iterations >1 skip I1/O1, use the stored states as I2/O2 chain, giving 4 compressions per iteration.
REQ-035 MIDSTATE_CACHE_EN undefined: no midstate registers; 6 compressions every iteration.
REQ-036 o_key is identical in both builds.

Verification
REQ-037 pass "password" (len 8), salt pattern, c=1, idx=1, 4-cycle stub vs reference model -> o_key matches model; exactly 6 o_cf_init pulses.
REQ-038 c=1000 -> 6000 init pulses without cache, 4002 with MIDSTATE_CACHE_EN; o_key equal in both builds.
REQ-039 i_pass_len=65 start -> o_err one cycle, o_ready stays 1, zero o_cf_init.
REQ-040 i_key_ready held 0 for 20 cycles after o_key_valid -> o_key stable, no new start accepted; ready=1 -> IDLE next cycle.
REQ-041 i_abort during O2 of iter 3, then spurious i_cf_valid -> IDLE, no o_key_valid; next job (c=2) correct.
REQ-042 i_rstn low during I2 -> all outputs at reset values immediately; i_iter=0 job -> same key as c=1.

Source files
------------

// File: rtl/pbkdf2_whirlpool_engine.sv
// PBKDF2 block-function sequencer around an external Whirlpool compression core.
// Optional MIDSTATE_CACHE_EN reuses the ikey/okey midstates after the first iteration.
module pbkdf2_whirlpool_engine #(
  parameter int ITER_W    = 20,
  parameter int BLK_IDX_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rstn,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [511:0]         i_pass,
  input  logic [6:0]           i_pass_len,
  input  logic [511:0]         i_salt,
  input  logic [ITER_W-1:0]    i_iter,
  input  logic [BLK_IDX_W-1:0] i_blk_idx,
  output logic                 o_ready,
  output logic                 o_key_valid,
  input  logic                 i_key_ready,
  output logic [511:0]         o_key,
  output logic                 o_err,
  output logic                 o_cf_init,
  output logic [511:0]         o_cf_data,
  output logic [511:0]         o_cf_chain,
  input  logic                 i_cf_valid,
  input  logic [511:0]         i_cf_out
);

  // state | meaning
  // IDLE  | waiting for a job      PAD  | build ikey/okey from the password
  // I1-I3 | inner hash blocks      O1-O3 | outer hash blocks
  // ACC   | fold U_j into key      DONE | hold key until accepted
  localparam logic [3:0] S_IDLE = 4'd0, S_PAD = 4'd1, S_I1 = 4'd2, S_I2 = 4'd3,
                         S_I3 = 4'd4, S_O1 = 4'd5, S_O2 = 4'd6, S_O3 = 4'd7,
                         S_ACC = 4'd8, S_DONE = 4'd9;
  localparam logic [511:0] PAD_LATE = {1'b1, 255'd0, 256'd1024};

  logic [3:0]           state, cf_next;
  logic                 pending;
  logic [511:0]         ikey, okey, salt_r, chain_r, inner_r, u_r, acc_r;
  logic [6:0]           len_r;
  logic [BLK_IDX_W-1:0] idx_r;
  logic [ITER_W-1:0]    iter_c, iter_cnt, iter_nxt;
  logic [511:0]         masked, req_data, req_chain, pad_first, chain_i2, chain_o2;
  logic                 first, skip_outer;
  logic [3:0]           s_loop;

`ifdef MIDSTATE_CACHE_EN
  logic [511:0] mid_i, mid_o;
  assign chain_i2   = mid_i;
  assign chain_o2   = mid_o;
  assign skip_outer = !first;
  assign s_loop     = S_I2;
`else
  assign chain_i2   = chain_r;
  assign chain_o2   = chain_r;
  assign skip_outer = 1'b0;
  assign s_loop     = S_I1;
`endif

  assign o_ready   = (state == S_IDLE);
  assign first     = (iter_cnt == '0);
  assign iter_nxt  = iter_cnt + 1'b1;
  assign pad_first = {32'(idx_r), 1'b1, 223'd0, 256'd1056};

  // ikey holds the raw password between acceptance and PAD
  always_comb begin
    masked = ikey;
    for (int k = 0; k < 64; k++)
      if (k >= int'(len_r)) masked[511-8*k -: 8] = 8'h00;
  end

  always_comb begin
    cf_next   = S_IDLE;
    req_data  = '0;
    req_chain = '0;
    case (state)
      S_I1: begin req_data = ikey; cf_next = S_I2; end
      S_I2: begin
        req_chain = chain_i2;
        req_data  = first ? salt_r : u_r;
        cf_next   = S_I3;
      end
      S_I3: begin
        req_chain = chain_r;
        req_data  = first ? pad_first : PAD_LATE;
        cf_next   = skip_outer ? S_O2 : S_O1;
      end
      S_O1: begin req_data = okey; cf_next = S_O2; end
      S_O2: begin req_chain = chain_o2; req_data = inner_r; cf_next = S_O3; end
      S_O3: begin req_chain = chain_r; req_data = PAD_LATE; cf_next = S_ACC; end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state       <= S_IDLE;
      pending     <= 1'b0;
      ikey        <= '0;
      okey        <= '0;
      salt_r      <= '0;
      chain_r     <= '0;
      inner_r     <= '0;
      u_r         <= '0;
      acc_r       <= '0;
      len_r       <= '0;
      idx_r       <= '0;
      iter_c      <= '0;
      iter_cnt    <= '0;
      o_key_valid <= 1'b0;
      o_key       <= '0;
      o_err       <= 1'b0;
      o_cf_init   <= 1'b0;
      o_cf_data   <= '0;
      o_cf_chain  <= '0;
`ifdef MIDSTATE_CACHE_EN
      mid_i       <= '0;
      mid_o       <= '0;
`endif
    end else begin
      o_err     <= 1'b0;
      o_cf_init <= 1'b0;
      if (i_abort && state != S_IDLE) begin
        state       <= S_IDLE;
        pending     <= 1'b0;
        o_key_valid <= 1'b0;
      end else begin
        case (state)
          S_IDLE: if (i_start) begin
            if (i_pass_len > 7'd64) o_err <= 1'b1;
            else begin
              ikey     <= i_pass;
              len_r    <= i_pass_len;
              salt_r   <= i_salt;
              idx_r    <= i_blk_idx;
              iter_c   <= (i_iter == '0) ? ITER_W'(1) : i_iter;
              iter_cnt <= '0;
              acc_r    <= '0;
              state    <= S_PAD;
            end
          end
          S_PAD: begin
            ikey  <= masked ^ {64{8'h36}};
            okey  <= masked ^ {64{8'h5c}};
            state <= S_I1;
          end
          S_ACC: begin
            acc_r    <= acc_r ^ u_r;
            iter_cnt <= iter_nxt;
            if (iter_nxt == iter_c) begin
              o_key       <= acc_r ^ u_r;
              o_key_valid <= 1'b1;
              state       <= S_DONE;
            end else state <= s_loop;
          end
          S_DONE: if (i_key_ready) begin
            o_key_valid <= 1'b0;
            state       <= S_IDLE;
          end
          default: begin
            if (!pending) begin
              o_cf_init  <= 1'b1;
              o_cf_data  <= req_data;
              o_cf_chain <= req_chain;
              pending    <= 1'b1;
            end else if (i_cf_valid) begin
              pending <= 1'b0;
              chain_r <= i_cf_out;
              state   <= cf_next;
              if (state == S_I3) inner_r <= i_cf_out;
              if (state == S_O3) u_r <= i_cf_out;
`ifdef MIDSTATE_CACHE_EN
              if (state == S_I1) mid_i <= i_cf_out;
              if (state == S_O1) mid_o <= i_cf_out;
`endif
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pbkdf2_whirlpool_engine.sv
// Directed bench: a 4-cycle stand-in compression stub plus an independent PBKDF2 model.
module tb_pbkdf2_whirlpool_engine;
`ifdef MIDSTATE_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic         i_clk, i_rstn, i_start, i_abort, i_key_ready, i_cf_valid;
  logic [511:0] i_pass, i_salt, i_cf_out;
  logic [6:0]   i_pass_len;
  logic [19:0]  i_iter;
  logic [7:0]   i_blk_idx;
  logic         o_ready, o_key_valid, o_err, o_cf_init;
  logic [511:0] o_key, o_cf_data, o_cf_chain;

  pbkdf2_whirlpool_engine #(.ITER_W(20), .BLK_IDX_W(8)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_abort(i_abort),
    .i_pass(i_pass), .i_pass_len(i_pass_len), .i_salt(i_salt), .i_iter(i_iter),
    .i_blk_idx(i_blk_idx), .o_ready(o_ready), .o_key_valid(o_key_valid),
    .i_key_ready(i_key_ready), .o_key(o_key), .o_err(o_err), .o_cf_init(o_cf_init),
    .o_cf_data(o_cf_data), .o_cf_chain(o_cf_chain), .i_cf_valid(i_cf_valid),
    .i_cf_out(i_cf_out)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [511:0] pass;
    logic [6:0]   len;
    logic [511:0] salt;
    logic [19:0]  iter;
    logic [7:0]   idx;
    logic         exp_err;
  } vec_t;

  int n_pass = 0, n_total = 0;
  int init_cnt = 0, overlap_cnt = 0, stub_cnt = 0;
  logic [511:0] s_ch, s_d;

  function automatic logic [511:0] cf(input logic [511:0] ch, input logic [511:0] d);
    return ({ch[506:0], ch[511:507]} + d) ^ {d[255:0], d[511:256]} ^ 512'h9e3779b97f4a7c15;
  endfunction

  function automatic logic [511:0] model_key(input logic [511:0] pass, input logic [6:0] len,
      input logic [511:0] salt, input logic [19:0] c, input logic [7:0] idx);
    logic [511:0] p, ik, ok, u, inner, acc, msg, blk;
    int cc;
    p = pass;
    for (int k = 0; k < 64; k++) if (k >= int'(len)) p[511-8*k -: 8] = 8'h00;
    ik  = p ^ {64{8'h36}};
    ok  = p ^ {64{8'h5c}};
    cc  = (c == 0) ? 1 : int'(c);
    acc = '0;
    u   = '0;
    for (int j = 1; j <= cc; j++) begin
      if (j == 1) begin msg = salt; blk = {24'd0, idx, 1'b1, 223'd0, 256'd1056}; end
      else begin msg = u; blk = {1'b1, 255'd0, 256'd1024}; end
      inner = cf(cf(cf(512'd0, ik), msg), blk);
      u     = cf(cf(cf(512'd0, ok), inner), {1'b1, 255'd0, 256'd1024});
      acc   = acc ^ u;
    end
    return acc;
  endfunction

  function automatic int exp_pulses(input logic [19:0] c);
    int cc;
    cc = (c == 0) ? 1 : int'(c);
    return CACHE ? 2 + 4 * cc : 6 * cc;
  endfunction

  // compression stub: answers each request 4 cycles later
  initial begin
    i_cf_valid = 1'b0;
    i_cf_out   = '0;
    forever begin
      @(negedge i_clk);
      i_cf_valid = 1'b0;
      if (!i_rstn) stub_cnt = 0;
      else if (o_cf_init) begin
        init_cnt++;
        if (stub_cnt != 0) overlap_cnt++;
        s_ch = o_cf_chain;
        s_d  = o_cf_data;
        stub_cnt = 4;
      end else if (stub_cnt != 0) begin
        stub_cnt--;
        if (stub_cnt == 0) begin
          i_cf_out   = cf(s_ch, s_d);
          i_cf_valid = 1'b1;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [511:0] got, input logic [511:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h required %0h", nm, got, exp);
  endtask

  task automatic start_job(input vec_t v, output logic err);
    @(negedge i_clk);
    i_pass = v.pass; i_pass_len = v.len; i_salt = v.salt;
    i_iter = v.iter; i_blk_idx = v.idx; i_start = 1'b1;
    @(negedge i_clk);
    err = o_err;
    i_start = 1'b0;
    i_pass = ~v.pass; i_pass_len = 7'd3; i_salt = ~v.salt; i_iter = 20'd7; i_blk_idx = 8'h55;
  endtask

  task automatic wait_key(input int budget, output logic got);
    got = 1'b0;
    for (int n = 0; n < budget && !got; n++) begin
      @(negedge i_clk);
      if (o_key_valid) got = 1'b1;
    end
  endtask

  task automatic wait_pulses(input int base, input int target, output logic got);
    got = 1'b0;
    for (int n = 0; n < 1000 && !got; n++) begin
      @(negedge i_clk);
      if (init_cnt - base >= target) got = 1'b1;
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v, output logic [511:0] key);
    int base;
    logic err, got;
    base = init_cnt;
    key  = '0;
    start_job(v, err);
    if (v.exp_err) begin
      check({nm, " err_pulse"}, err, 1);
      @(negedge i_clk);
      check({nm, " err_one_cycle"}, o_err, 0);
      repeat (5) @(negedge i_clk);
      check({nm, " ready_kept"}, o_ready, 1);
      check({nm, " no_cf_init"}, init_cnt - base, 0);
    end else begin
      check({nm, " no_err"}, err, 0);
      wait_key(8 * exp_pulses(v.iter) + 100, got);
      check({nm, " key_valid"}, got, 1);
      key = o_key;
      check({nm, " key"}, key, model_key(v.pass, v.len, v.salt, v.iter, v.idx));
      check({nm, " cf_pulses"}, init_cnt - base, exp_pulses(v.iter));
      check({nm, " no_overlap"}, overlap_cnt, 0);
      @(negedge i_clk);
      check({nm, " back_idle"}, o_ready & ~o_key_valid, 1);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t va;
    logic [511:0] key, key0, k0;
    logic err, got;
    int base, base2, bad;
    logic [511:0] pw, salt_a, salt_b, full;

    pw     = {64'h70617373776f7264, 448'd0};
    salt_a = {8{64'h0123456789abcdef}};
    salt_b = {16{32'hc3a5_1e0f}};
    full   = {16{32'hdeadbeef}} ^ {64{8'h3c}};
    vecs[0] = '{pass: pw,           len: 7'd8,  salt: salt_a, iter: 20'd1,    idx: 8'd1,   exp_err: 1'b0};
    vecs[1] = '{pass: {64{8'hff}},  len: 7'd0,  salt: salt_b, iter: 20'd2,    idx: 8'd2,   exp_err: 1'b0};
    vecs[2] = '{pass: full,         len: 7'd64, salt: salt_a, iter: 20'd3,    idx: 8'hff,  exp_err: 1'b0};
    vecs[3] = '{pass: pw,           len: 7'd65, salt: salt_a, iter: 20'd1,    idx: 8'd1,   exp_err: 1'b1};
    vecs[4] = '{pass: pw,           len: 7'd8,  salt: salt_a, iter: 20'd0,    idx: 8'd1,   exp_err: 1'b0};
    vecs[5] = '{pass: {64{8'ha7}},  len: 7'd5,  salt: salt_b, iter: 20'd1,    idx: 8'd3,   exp_err: 1'b0};
    vecs[6] = '{pass: pw,           len: 7'd8,  salt: salt_a, iter: 20'd1000, idx: 8'd1,   exp_err: 1'b0};

    i_rstn = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_key_ready = 1'b1;
    i_pass = '0; i_pass_len = '0; i_salt = '0; i_iter = '0; i_blk_idx = '0;
    repeat (2) @(negedge i_clk);
    check("reset ready", o_ready, 1);
    check("reset key_valid", o_key_valid, 0);
    check("reset key", o_key, 0);
    check("reset cf_init", o_cf_init, 0);
    check("reset cf_data", o_cf_data, 0);
    i_rstn = 1'b1;
    @(negedge i_clk);

    key0 = '0;
    for (int i = 0; i < 7; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i], key);
      if (i == 0) key0 = key;
      if (i == 4) check("iter0_equals_c1", key, key0);
    end

    // key held back by the consumer
    i_key_ready = 1'b0;
    base = init_cnt;
    start_job(vecs[0], err);
    wait_key(200, got);
    check("hold key_valid", got, 1);
    k0 = o_key;
    bad = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge i_clk);
      if (!o_key_valid || o_key !== k0 || o_ready) bad++;
      i_start = (n == 5);
    end
    check("hold stable", bad, 0);
    check("hold no_new_job", init_cnt - base, exp_pulses(20'd1));
    check("hold key", k0, model_key(pw, 7'd8, salt_a, 20'd1, 8'd1));
    i_key_ready = 1'b1;
    @(negedge i_clk);
    check("hold release", {o_ready, o_key_valid}, 2'b10);

    // abort during O2 of the third iteration
    va = '{pass: pw, len: 7'd8, salt: salt_b, iter: 20'd5, idx: 8'd1, exp_err: 1'b0};
    base = init_cnt;
    start_job(va, err);
    wait_pulses(base, CACHE ? 13 : 17, got);
    check("abort reached_o2", got, 1);
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    check("abort idle", {o_ready, o_key_valid}, 2'b10);
    base2 = init_cnt;
    bad = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_key_valid) bad++;
    end
    check("abort no_key", bad, 0);
    check("abort no_cf", init_cnt - base2, 0);
    va.iter = 20'd2;
    run_vec("after_abort", va, key);

    // reset in the middle of I2
    base = init_cnt;
    start_job(vecs[0], err);
    wait_pulses(base, 2, got);
    check("rst reached_i2", got, 1);
    i_rstn = 1'b0;
    #1;
    check("rst ready", o_ready, 1);
    check("rst key", o_key, 0);
    check("rst cf_data", o_cf_data, 0);
    check("rst cf_chain", o_cf_chain, 0);
    check("rst flags", {o_key_valid, o_err, o_cf_init}, 0);
    repeat (2) @(negedge i_clk);
    i_rstn = 1'b1;
    base2 = init_cnt;
    bad = 0;
    repeat (20) begin
      @(negedge i_clk);
      if (o_key_valid) bad++;
    end
    check("rst no_key", bad, 0);
    check("rst no_cf", init_cnt - base2, 0);
    run_vec("after_rst_iter0", vecs[4], key);
    check("after_rst_equals_c1", key, key0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
